// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/ack channel and the
// valid/ready output register feeding decode.
interface fetch_unit_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned ILEN = 32
);
    logic            imemReq;
    logic [XLEN-1:0] imemAddr;
    logic            imemAck;
    logic [ILEN-1:0] imemData;
    logic            ifValid;
    logic [XLEN-1:0] ifPc;
    logic [ILEN-1:0] ifInstr;
    logic            decodeReady;

    modport master (
        output imemReq, imemAddr, ifValid, ifPc, ifInstr,
        input  imemAck, imemData, decodeReady
    );

    modport slave (
        input  imemReq, imemAddr, ifValid, ifPc, ifInstr,
        output imemAck, imemData, decodeReady
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: one outstanding imem request, output register
// with one-entry skid buffer, PC advance/stall control and redirect draining.
module fetch_unit #(
    parameter int unsigned     XLEN      = 64,
    parameter int unsigned     ILEN      = 32,
    parameter logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] nextPc,
    output logic            pcStall,
    input  logic            redirectValid,
    input  logic [XLEN-1:0] redirectTarget,
    fetch_unit_if.master    bus
);

    typedef enum logic [1:0] {StIdle, StReq, StHold, StDrain} state_e;

    state_e          state_q, state_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [ILEN-1:0] if_instr_q, if_instr_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [ILEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] drain_addr_q, drain_addr_d;
    logic            slot_free;
    logic            redirect;
    logic            unused_tgt_lsb;

    assign unused_tgt_lsb = ^redirectTarget[1:0];

    assign bus.ifValid = if_valid_q;
    assign bus.ifPc    = if_pc_q;
    assign bus.ifInstr = if_instr_q;

    always_comb begin
        slot_free = !if_valid_q || bus.decodeReady;
        // Redirect must not release the PC while the block is held in reset.
        redirect  = redirectValid && resetN;

        state_d      = state_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        drain_addr_d = drain_addr_q;
        pcStall      = 1'b1;
        nextPc       = pc;
        bus.imemReq  = 1'b0;
        bus.imemAddr = pc;

        if (if_valid_q && bus.decodeReady) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end

        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                bus.imemReq  = 1'b1;
                bus.imemAddr = pc;
                if (bus.imemAck) begin
                    pcStall = 1'b0;
                    nextPc  = pc + XLEN'(4);
                    if (slot_free) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc;
                        if_instr_d = bus.imemData;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_pc_d    = pc;
                        skid_instr_d = bus.imemData;
                        state_d      = StHold;
                    end
                end
            end
            StHold: begin
                if (bus.decodeReady && skid_valid_q) begin
                    if_valid_d   = 1'b1;
                    if_pc_d      = skid_pc_q;
                    if_instr_d   = skid_instr_q;
                    skid_valid_d = 1'b0;
                    state_d      = StReq;
                end
            end
            StDrain: begin
                // Keep the abandoned request stable until memory answers it.
                bus.imemReq  = 1'b1;
                bus.imemAddr = drain_addr_q;
                if (bus.imemAck) state_d = StReq;
            end
            default: state_d = StIdle;
        endcase

        if (redirect) begin
            nextPc       = {redirectTarget[XLEN-1:2], 2'b00};
            pcStall      = 1'b0;
            if_valid_d   = 1'b0;
            if_pc_d      = if_pc_q;
            if_instr_d   = NOP_INSTR;
            skid_valid_d = 1'b0;
            case (state_q)
                StReq: begin
                    if (!bus.imemAck) begin
                        drain_addr_d = pc;
                        state_d      = StDrain;
                    end else begin
                        state_d = StReq;
                    end
                end
                StDrain: state_d = StDrain;
                default: state_d = StReq;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= StIdle;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= NOP_INSTR;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            drain_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            drain_addr_q <= drain_addr_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch sequencer sitting directly downstream of the 64-bit program counter register and upstream of decode. It consumes the current `pc`, issues one instruction-memory request at a time, and delivers `{pc, instruction}` pairs to decode through a valid/ready output register backed by a one-entry skid buffer. It also produces `nextPc` and `pcStall` for the program counter, and handles branch/jump redirects from execute, including discarding an in-flight fetch.

## Interface
- `XLEN`, 64, address / PC width
- `ILEN`, 32, instruction width
- `NOP_INSTR`, 32'h00000013, value held in `ifInstr` while invalid or after reset
- `clk`  in  1  rising-edge clock
- `resetN`  in  1  asynchronous, active-low reset
- `pc`  in  XLEN  current program counter value
- `nextPc`  out  XLEN  next program counter value
- `pcStall`  out  1  1 = program counter holds
- `imemReq`  out  1  fetch request, held until acknowledged
- `imemAddr`  out  XLEN  fetch address, stable while `imemReq`=1
- `imemAck`  in  1  one-cycle response strobe
- `imemData`  in  ILEN  instruction, valid with `imemAck`
- `redirectValid`  in  1  one-cycle redirect from execute
- `redirectTarget`  in  XLEN  redirect PC
- `ifValid`  out  1  output register holds a valid instruction
- `ifPc`  out  XLEN  PC of `ifInstr`
- `ifInstr`  out  ILEN  fetched instruction
- `decodeReady`  in  1  decode accepts the output this cycle

## Operation
- State register with four states: IDLE, REQ, HOLD, DRAIN. Registered outputs are `ifValid`, `ifPc`, `ifInstr`, `skid*`, and `drainAddr`. `imemReq`, `imemAddr`, `nextPc`, and `pcStall` are combinational from state and inputs.
- `slotFree` = `!ifValid || decodeReady`.
- Default outputs: `pcStall`=1, `nextPc`=`pc`.
- Output dequeue: if `ifValid && decodeReady` and no reload occurs, `ifValid` goes to 0 and `ifInstr` goes to `NOP_INSTR`.
- **IDLE** (entered at reset): `imemReq`=0. Moves to REQ on the first clock edge after reset release.
- **REQ**: `imemReq`=1, `imemAddr`=`pc`.
  - On `imemAck` with `slotFree`: load `ifPc`=`pc`, `ifInstr`=`imemData`, `ifValid`=1. Drive `pcStall`=0, `nextPc`=`pc`+4. Stay in REQ.
  - On `imemAck` without `slotFree`: capture `pc` and `imemData` into the skid buffer. Drive `pcStall`=0, `nextPc`=`pc`+4. Go to HOLD.
- **HOLD**: `imemReq`=0. On `decodeReady`, move the skid buffer into the output register (`ifValid` stays 1) and go to REQ.
- **DRAIN**: `imemReq`=1, `imemAddr`=`drainAddr`. On `imemAck`, discard `imemData` and go to REQ.
- **Redirect** (`redirectValid`=1) has priority over everything above:
  - Drive `nextPc`=`{redirectTarget[XLEN-1:2],2'b00}` and `pcStall`=0.
  - Next cycle: `ifValid`=0, `ifInstr`=`NOP_INSTR`, skid buffer invalidated.
  - In REQ without `imemAck`: latch `drainAddr`=`pc` and go to DRAIN.
  - In REQ with `imemAck`: drop the data and stay in REQ.
  - In HOLD: go to REQ.
  - In DRAIN: stay in DRAIN, keep `drainAddr`, and discard the next ack.
  - In IDLE: go to REQ.
  - An instruction consumed by decode in the redirect cycle counts as accepted. Flushing it is decode's responsibility.
- PC arithmetic is modulo 2^XLEN. `pc`=64'hFFFF_FFFF_FFFF_FFFC advances to 0.
- `imemAck` while `imemReq`=0 is ignored.

## Timing
- Reset values: state=IDLE, `ifValid`=0, `ifPc`=0, `ifInstr`=`NOP_INSTR`, skid buffer invalid, `drainAddr`=0.
- While in reset, outputs are `imemReq`=0 and `pcStall`=1.
- Reset assertion mid-operation returns immediately to the reset values. Any outstanding memory request is abandoned, and the memory side is reset by the same `resetN`.
- Zero-wait memory (`imemAck` in the same cycle as `imemReq`) sustains one instruction per cycle. `ifValid` rises on the edge after the ack.
- N-cycle memory latency gives a throughput of one instruction per N+1 cycles.
- Redirect penalty: the fetch for the target is issued the cycle after the redirect if nothing is in flight. Otherwise it is issued the cycle after the drained ack.
- `imemAddr` and `imemReq` must not change between request assertion and ack, including across redirects.

## Test plan
- **Reset and startup:** hold `resetN`=0 for 3 cycles with `pc`=0. Expect `imemReq`=0, `ifValid`=0, `ifInstr`=0x00000013. After release, expect `imemReq`=1 with `imemAddr`=0 on cycle 2.
- **Streaming:** zero-wait memory, `decodeReady`=1, `pc` fed back from `nextPc` through a PC register. Expect `ifPc` sequence 0,4,8,12 on consecutive cycles, with `ifInstr` matching memory.
- **Backpressure:** `decodeReady`=0 after the first instruction. Expect the second ack to land in the skid buffer, `imemReq`=0, and `pcStall`=1. Raise `decodeReady`: expect `ifPc`=4 then 8 with no instruction lost or duplicated.
- **Redirect while waiting:** 3-cycle memory latency, redirect to 0x1002 one cycle after the request for 0x10. Expect `imemAddr` held at 0x10 until its ack, that data discarded, then a request to 0x1000. Expect `ifPc`=0x1000.
- **Redirect coincident with ack:** redirect to 0x200 in the same cycle as the ack for 0x40. Expect the 0x40 data dropped, `ifValid`=0 the next cycle, and the next request at 0x200.
- **Wrap-around:** `pc`=64'hFFFF_FFFF_FFFF_FFFC with an ack. Expect `nextPc`=0.
